// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared RV32M opcode constants and MDU state type
package riscv_defines;

  localparam int MD_OP_WIDTH = 3;

  // Encoding follows the RV32M funct3 field.
  // Bit 2 selects divide; bit 1 within the divides selects remainder.
  localparam logic [MD_OP_WIDTH-1:0] MD_MUL    = 3'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULH   = 3'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULHSU = 3'd2;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULHU  = 3'd3;
  localparam logic [MD_OP_WIDTH-1:0] MD_DIV    = 3'd4;
  localparam logic [MD_OP_WIDTH-1:0] MD_DIVU   = 3'd5;
  localparam logic [MD_OP_WIDTH-1:0] MD_REM    = 3'd6;
  localparam logic [MD_OP_WIDTH-1:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [MD_OP_WIDTH-1:0] op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input logic [MD_OP_WIDTH-1:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - one combinational radix-2 multiply/divide step
// Ports:
//   i_div      : 1 = restoring divide step, 0 = shift-add multiply step
//   i_hi, i_lo : current partial state (multiply: product hi/lo, divide: remainder/quotient)
//   i_b        : multiplicand (multiply) or divisor magnitude (divide)
//   o_hi, o_lo : state after this step
module mdu_iter #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  i_div,
  input  logic [WORD_WIDTH-1:0] i_hi,
  input  logic [WORD_WIDTH-1:0] i_lo,
  input  logic [WORD_WIDTH-1:0] i_b,
  output logic [WORD_WIDTH-1:0] o_hi,
  output logic [WORD_WIDTH-1:0] o_lo
);

  logic [WORD_WIDTH-1:0] w_addend;
  logic [WORD_WIDTH:0]   w_sum;
  logic [WORD_WIDTH:0]   w_shift;
  logic [WORD_WIDTH:0]   w_diff;

  // Multiply: multiplier sits in i_lo and is consumed LSB first while the
  // product shifts in from the top, so after WORD_WIDTH steps {hi,lo} is
  // the full product.
  assign w_addend = i_lo[0] ? i_b : '0;
  assign w_sum    = {1'b0, i_hi} + {1'b0, w_addend};

  // Divide: remainder stays below the divisor, so the shifted remainder
  // fits in WORD_WIDTH+1 bits and the top bit of the difference is the borrow.
  assign w_shift = {i_hi, i_lo[WORD_WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_b};

  always_comb begin
    if (i_div) begin
      o_hi = w_diff[WORD_WIDTH] ? w_shift[WORD_WIDTH-1:0] : w_diff[WORD_WIDTH-1:0];
      o_lo = {i_lo[WORD_WIDTH-2:0], ~w_diff[WORD_WIDTH]};
    end else begin
      o_hi = w_sum[WORD_WIDTH:1];
      o_lo = {w_sum[0], i_lo[WORD_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - sequential RV32M multiply/divide unit, one bit per cycle
// Ports:
//   clk_i, rst_i               : clock, synchronous active-high reset
//   operand_a_i, operand_b_i   : dividend/multiplicand, divisor/multiplier
//   operator_i                 : MD_* opcode
//   valid_i / ready_o          : request handshake (ready only in IDLE)
//   kill_i                     : abandon the operation in flight
//   result_o / valid_o / ready_i : result handshake
module mdu_seq
  import riscv_defines::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(WORD_WIDTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [WORD_WIDTH-1:0]  operand_a_i,
  input  logic [WORD_WIDTH-1:0]  operand_b_i,
  input  logic [MD_OP_WIDTH-1:0] operator_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   kill_i,
  output logic [WORD_WIDTH-1:0]  result_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam logic [CNT_WIDTH-1:0]  CNT_LOAD = CNT_WIDTH'(WORD_WIDTH - 1);
  localparam logic [WORD_WIDTH-1:0] MOST_NEG = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  md_state_e               r_state;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [WORD_WIDTH-1:0]   r_hi;
  logic [WORD_WIDTH-1:0]   r_lo;
  logic [WORD_WIDTH-1:0]   r_b;
  logic [MD_OP_WIDTH-1:0]  r_op;
  logic                    r_neg;
  logic [WORD_WIDTH-1:0]   r_result;
  logic                    r_valid;

  logic                    w_accept;
  logic                    w_is_div;
  logic                    w_is_rem;
  logic                    w_a_signed;
  logic                    w_b_signed;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic                    w_neg;
  logic [WORD_WIDTH-1:0]   w_a_mag;
  logic [WORD_WIDTH-1:0]   w_b_mag;
  logic                    w_div_zero;
  logic                    w_div_ovf;
  logic [WORD_WIDTH-1:0]   w_special_res;
  logic                    w_op_div;
  logic [WORD_WIDTH-1:0]   w_hi_n;
  logic [WORD_WIDTH-1:0]   w_lo_n;
  logic [2*WORD_WIDTH-1:0] w_prod;
  logic [2*WORD_WIDTH-1:0] w_prod_fix;
  logic [WORD_WIDTH-1:0]   w_quo_fix;
  logic [WORD_WIDTH-1:0]   w_rem_fix;
  logic [WORD_WIDTH-1:0]   w_result;

  assign ready_o  = (r_state == IDLE);
  assign valid_o  = r_valid;
  assign result_o = r_result;

  // kill_i in IDLE has no operation to abort but still suppresses accept.
  assign w_accept = valid_i && ready_o && !kill_i;

  assign w_is_div   = md_is_div(operator_i);
  assign w_is_rem   = md_is_rem(operator_i);
  assign w_a_signed = (operator_i == MD_MULH) || (operator_i == MD_MULHSU) ||
                      (operator_i == MD_DIV)  || (operator_i == MD_REM);
  assign w_b_signed = (operator_i == MD_MULH) || (operator_i == MD_DIV) ||
                      (operator_i == MD_REM);
  assign w_a_neg    = w_a_signed && operand_a_i[WORD_WIDTH-1];
  assign w_b_neg    = w_b_signed && operand_b_i[WORD_WIDTH-1];
  assign w_a_mag    = w_a_neg ? -operand_a_i : operand_a_i;
  assign w_b_mag    = w_b_neg ? -operand_b_i : operand_b_i;

  // Remainder takes the dividend's sign; everything else the XOR of both.
  // MUL never negates: the low word is identical for signed and unsigned.
  assign w_neg = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = w_is_div && (operand_b_i == '0);
  assign w_div_ovf  = ((operator_i == MD_DIV) || (operator_i == MD_REM)) &&
                      (operand_a_i == MOST_NEG) && (operand_b_i == '1);
  assign w_special_res = w_div_zero ? (w_is_rem ? operand_a_i : '1)
                                    : (w_is_rem ? '0 : operand_a_i);

  assign w_op_div = md_is_div(r_op);

  mdu_iter #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_iter (
    .i_div(w_op_div),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .i_b  (r_b),
    .o_hi (w_hi_n),
    .o_lo (w_lo_n)
  );

  // Sign fix applied to the output of the final step as DONE is entered.
  assign w_prod     = {w_hi_n, w_lo_n};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg ? -w_lo_n : w_lo_n;
  assign w_rem_fix  = r_neg ? -w_hi_n : w_hi_n;

  always_comb begin
    w_result = w_prod_fix[WORD_WIDTH-1:0];
    case (r_op)
      MD_MULH, MD_MULHSU, MD_MULHU: w_result = w_prod_fix[2*WORD_WIDTH-1:WORD_WIDTH];
      MD_DIV, MD_DIVU:              w_result = w_quo_fix;
      MD_REM, MD_REMU:              w_result = w_rem_fix;
      default:                      w_result = w_prod_fix[WORD_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_op     <= MD_MUL;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op  <= operator_i;
            r_neg <= w_neg;
            r_cnt <= CNT_LOAD;
            r_hi  <= '0;
            // Multiply keeps the multiplier in lo (consumed LSB first);
            // divide keeps the dividend in lo (consumed MSB first).
            if (w_is_div) begin
              r_lo <= w_a_mag;
              r_b  <= w_b_mag;
            end else begin
              r_lo <= w_b_mag;
              r_b  <= w_a_mag;
            end
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_special_res;
              r_valid  <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill_i) begin
            r_state <= IDLE;
          end else begin
            r_hi <= w_hi_n;
            r_lo <= w_lo_n;
            if (r_cnt == '0) begin
              r_result <= w_result;
              r_valid  <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_cnt <= r_cnt - CNT_WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (kill_i || ready_i) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard testbench for mdu_seq
module tb_mdu_seq;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic        clk;
  logic        rst_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic [2:0]  operator_i;
  logic        valid_i;
  logic        ready_o;
  logic        kill_i;
  logic [31:0] result_o;
  logic        valid_o;
  logic        ready_i;

  int nvec = 0;
  int nmis = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  mdu_seq #(.WORD_WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .operator_i (operator_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .kill_i     (kill_i),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got no end, required end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the RV32M rules.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MUL:    begin p = ua * ub;              return p[31:0];  end
      OP_MULH:   begin p = sa * sb;              return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub);    return p[63:32]; end
      OP_MULHU:  begin p = ua * ub;              return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        p = sa / sb; return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_div, signed_div;
    is_div     = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    signed_div = (op == OP_DIV) || (op == OP_REM);
    if (is_div && b == 0) return 1;
    if (signed_div && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Present one request in IDLE; expected response goes to the scoreboard
  // only when the operation is meant to complete.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) begin
      nvec++;
      nmis++;
      $display("FAIL ready_timeout: got ready_o 0 required 1");
      return;
    end
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    valid_i     = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
    end
    @(negedge clk);
    valid_i     = 1'b0;
    operator_i  = 3'($urandom);
    operand_a_i = $urandom;
    operand_b_i = $urandom;
  endtask

  task automatic finish_op(input int hold);
    int t;
    t = 0;
    while (!valid_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!valid_o) begin
      nvec++;
      nmis++;
      $display("FAIL valid_timeout: got valid_o 0 required 1");
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
      end
      return;
    end
    repeat (hold) @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input int hold);
    issue(op, a, b, exp, lat, 1'b1);
    finish_op(hold);
  endtask

  initial begin : monitor
    bit          p_exit, p_rst, p_valid;
    int          s, acc_s, lat_exp;
    logic [31:0] held, exp_r;
    p_exit = 1'b0;
    p_rst = 1'b0;
    p_valid = 1'b0;
    s = 0;
    acc_s = 0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      s++;
      if (p_exit) begin
        chk("idle_ready", 32'(ready_o), 32'd1);
        chk("idle_valid", 32'(valid_o), 32'd0);
      end
      if (p_rst) chk("rst_result", result_o, 32'd0);
      if (valid_o && !p_valid) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL unexpected_valid: got result %h required no valid_o", result_o);
        end else begin
          exp_r   = exp_q.pop_front();
          lat_exp = lat_q.pop_front();
          chk("result", result_o, exp_r);
          chk("latency", 32'(s - acc_s), 32'(lat_exp));
        end
        held = result_o;
      end else if (valid_o) begin
        chk("hold_result", result_o, held);
        chk("hold_ready", 32'(ready_o), 32'd0);
      end
      if (valid_i && ready_o && !kill_i && !rst_i) acc_s = s;
      p_exit  = rst_i || kill_i || (valid_o && ready_i);
      p_rst   = rst_i;
      p_valid = valid_o;
    end
  end

  initial begin : stim
    logic [2:0]  op;
    logic [31:0] a, b;
    rst_i = 1'b1;
    valid_i = 1'b0;
    kill_i = 1'b0;
    ready_i = 1'b0;
    operand_a_i = '0;
    operand_b_i = '0;
    operator_i = OP_MUL;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    run(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 1);
    run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 2);
    run(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run(OP_DIVU,   32'd100,      32'd7,        32'd14,       33, 0);
    run(OP_REMU,   32'd100,      32'd7,        32'd2,        33, 0);
    run(OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run(OP_REM,    32'd5,        32'd0,        32'd5,        1,  0);
    run(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
    run(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);
    run(OP_DIVU,   32'd1000,     32'd10,       32'd100,      33, 5);

    // Abort in CALC cycle 10 by kill_i, then by reset.
    issue(OP_MUL, 32'h1234, 32'h5678, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    repeat (40) @(negedge clk);
    run(OP_MUL, 32'd3, 32'd4, 32'd12, 33, 0);

    issue(OP_DIVU, 32'hDEADBEEF, 32'd3, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (40) @(negedge clk);
    run(OP_MUL, 32'd3, 32'd4, 32'd12, 33, 0);

    // kill_i in IDLE must block a simultaneous request.
    @(negedge clk);
    operator_i = OP_MUL;
    operand_a_i = 32'd9;
    operand_b_i = 32'd9;
    valid_i = 1'b1;
    kill_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    kill_i = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 160; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      issue(op, a, b, ref_result(op, a, b), ref_lat(op, a, b), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        valid_i = 1'b1;
        operator_i = 3'($urandom);
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        @(negedge clk);
        valid_i = 1'b0;
      end
      finish_op($urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, datapath width (even, >=8).
REQ-002 SHALL have parameter CNT_WIDTH, default $clog2(WORD_WIDTH)+1, iteration-counter width.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: operand_a_i  in  WORD_WIDTH  dividend/multiplicand; operand_b_i  in  WORD_WIDTH  divisor/multiplier; operator_i  in  MD_OP_WIDTH  operation code.
REQ-005 SHALL have ports: valid_i  in  1  request valid; ready_o  out  1  request accepted; kill_i  in  1  abort current operation.
REQ-006 SHALL have ports: result_o  out  WORD_WIDTH  result; valid_o  out  1  result valid; ready_i  in  1  consumer accepts result.

Function
REQ-007 SHALL support MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU with RV32M semantics at WORD_WIDTH.
REQ-008 SHALL implement FSM states IDLE, CALC, DONE; ready_o = 1 only in IDLE.
REQ-009 SHALL accept a request when valid_i && ready_o; operands and operator registered on that edge.
REQ-010 IDLE->CALC on accept, except divide-by-zero or signed overflow (DIV/REM, a = most-negative, b = -1): IDLE->DONE directly.
REQ-011 CALC: one radix-2 step per cycle (shift-add for multiply on 2*WORD_WIDTH product, restoring shift-subtract for divide), counter loads WORD_WIDTH-1 on accept, decrements, CALC->DONE when counter is 0 and the step completes.
REQ-012 Latency: normal ops valid_o asserted WORD_WIDTH+1 cycles after accept edge; special-case divides 1 cycle.
REQ-013 Signed ops: operate on magnitudes, fix sign at DONE entry; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a); MULHSU treats only a as signed.
REQ-014 Divide by zero: quotient all-ones, remainder = operand_a; signed overflow: quotient = operand_a, remainder 0.
REQ-015 MUL returns low word; MULH* return high word of the 2*WORD_WIDTH product.
REQ-016 DONE: valid_o = 1, result_o stable until ready_i sampled high; then DONE->IDLE (no same-cycle new accept).
REQ-017 kill_i high in CALC or DONE: next state IDLE, valid_o low next cycle, no result delivered; kill_i in IDLE ignored and blocks accept that cycle.
REQ-018 valid_i/operands SHALL be ignored outside IDLE; no request queueing.

Reset
REQ-019 rst_i high: state IDLE, counter 0, valid_o 0, result_o 0, internal product/quotient registers 0, next cycle ready_o 1.
REQ-020 Reset mid-CALC or DONE SHALL discard the operation with no valid_o pulse; reset has priority over kill_i and valid_i.

Structure
REQ-021 MD_OP_WIDTH (3) and MD_* opcode constants, and the state enum typedef, SHALL live in the shared riscv_defines package.
REQ-022 SHALL instantiate one sub-module, mdu_iter: combinational single radix-2 step (add or subtract-compare, shift), parametrised by WORD_WIDTH.
REQ-023 FSM, counter, sign-fix and output registers SHALL stay in mdu_seq; no multiplier/divider operators (*, /, %) in RTL.

Verification (WORD_WIDTH=32)
REQ-024 MUL 7 x 0xFFFFFFFD -> result_o 0xFFFFFFEB, valid_o exactly 33 cycles after accept.
REQ-025 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-026 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-027 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, each valid_o 1 cycle after accept.
REQ-028 ready_i low 5 cycles in DONE -> result_o/valid_o held constant, IDLE one cycle after ready_i high; ready_o low throughout.
REQ-029 kill_i at CALC cycle 10, and separately rst_i at CALC cycle 10 -> no valid_o, ready_o 1 next cycle, following MUL 3x4 -> 12.
